mem_arbiter: RTL and testbench

//  Shares the single pipelined main memory between the icache fill path and the dcache (fills + write-through stores).

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares main memory between the icache fill path and the dcache (fills and write-through stores).
// Generates the 8 word addresses of each 16-byte fill and steers returning beats to the owning cache.
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  if (MEM_LAT < 1 || STARVE_LIM < 1) begin : g_bad_params
    $error("mem_arbiter: MEM_LAT and STARVE_LIM must both be at least 1");
  end

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [2:0]      r_k;
  logic [2:0]      r_r;
  logic            r_issued;
  logic [SW-1:0]   r_starve;
  logic            w_grant_d, w_grant_i, w_fill, w_beat;

  // dcache wins unless icache is pending and has already been passed over STARVE_LIM times
  assign w_grant_d = (r_state == IDLE) && d_req && (!i_req || (r_starve < SW'(STARVE_LIM)));
  assign w_grant_i = (r_state == IDLE) && i_req && !w_grant_d;
  assign w_fill    = (r_state == I_FILL) || (r_state == D_FILL);
  assign w_beat    = w_fill && mem_data_valid;
  assign fill_data = mem_rdata;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_addr    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next = d_wr ? D_WRITE : D_FILL;
        else if (w_grant_i) w_next = I_FILL;
      end
      D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        d_done    = 1'b1;
        w_next    = IDLE;
      end
      I_FILL, D_FILL: begin
        mem_en    = !r_issued;
        if (!r_issued) mem_addr = {r_addr[15:4], r_k, 1'b0};
        fill_addr = {r_addr[15:4], r_r, 1'b0};
        if (mem_data_valid) begin
          i_fill_valid = (r_state == I_FILL);
          d_fill_valid = (r_state == D_FILL);
          if (r_r == 3'd7) begin
            i_done = (r_state == I_FILL);
            d_done = (r_state == D_FILL);
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_k      <= '0;
      r_r      <= '0;
      r_issued <= 1'b0;
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      r_k      <= '0;
      r_r      <= '0;
      r_issued <= 1'b0;
      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        if (i_req) r_starve <= r_starve + SW'(1);
      end else if (w_grant_i) begin
        r_addr   <= i_addr;
        r_starve <= '0;
      end
    end else if (w_fill) begin
      if (!r_issued) begin
        r_k <= r_k + 3'd1;
        if (r_k == 3'd7) r_issued <= 1'b1;
      end
      if (w_beat) r_r <= r_r + 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model, timeline reference model checked every cycle,
// a table of single-requester operations, directed corner sequences and a randomized phase.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic        mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done, busy;
  logic [15:0] mem_addr, mem_wdata, fill_addr, fill_data;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  // Memory: a read issued in cycle c returns (addr ^ 5A5A) in cycle c+LAT.
  logic [LAT-1:0] vp = '0;
  logic [15:0]    ap [LAT];
  logic           spur = 1'b0;
  logic [15:0]    spur_data = '0;

  always @(posedge clk) begin
    vp    <= {vp[LAT-2:0], mem_en & ~mem_wr};
    ap[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end

  assign mem_data_valid = vp[LAT-1] | spur;
  assign mem_rdata      = vp[LAT-1] ? (ap[LAT-1] ^ 16'h5A5A) : spur_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: current operation as (kind, offset into its fixed-length timeline).
  // kind 0 = icache fill, 1 = dcache fill, 2 = dcache store.
  bit          m_active = 1'b0;
  int          m_kind, m_off, m_starve = 0;
  logic [15:0] m_addr, m_data;

  logic        e_en, e_wr, e_ifv, e_dfv, e_idone, e_ddone, e_busy;
  logic [15:0] e_maddr, e_mwdata, e_faddr;
  logic        s_en, s_wr, s_ifv, s_dfv, s_idone, s_ddone, s_busy;
  logic [15:0] s_maddr, s_mwdata, s_faddr, s_fdata;

  function automatic int op_len(input int k);
    return (k == 2) ? 1 : 8 + LAT;
  endfunction

  function automatic void model_expect();
    int b;
    {e_en, e_wr, e_ifv, e_dfv, e_idone, e_ddone} = '0;
    e_maddr = '0; e_mwdata = '0; e_faddr = '0;
    e_busy  = m_active;
    if (m_active) begin
      if (m_kind == 2) begin
        e_en = 1'b1; e_wr = 1'b1; e_maddr = m_addr; e_mwdata = m_data; e_ddone = 1'b1;
      end else begin
        if (m_off < 8) begin
          e_en    = 1'b1;
          e_maddr = (m_addr & 16'hFFF0) | 16'(m_off * 2);
        end
        if (m_off >= LAT) begin
          b       = m_off - LAT;
          e_faddr = (m_addr & 16'hFFF0) | 16'(b * 2);
          e_ifv   = (m_kind == 0);
          e_dfv   = (m_kind == 1);
          e_idone = (m_kind == 0) && (b == 7);
          e_ddone = (m_kind == 1) && (b == 7);
        end
      end
    end
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      m_active = 1'b0;
      m_starve = 0;
    end else if (m_active) begin
      m_off++;
      if (m_off == op_len(m_kind)) m_active = 1'b0;
    end else if (d_req && (!i_req || m_starve < LIM)) begin
      m_active = 1'b1; m_off = 0; m_kind = d_wr ? 2 : 1;
      m_addr = d_addr; m_data = d_wdata;
      if (i_req) m_starve++;
    end else if (i_req) begin
      m_active = 1'b1; m_off = 0; m_kind = 0; m_addr = i_addr;
      m_starve = 0;
    end
  endfunction

  // One cycle: compare at the falling edge, advance the model at the rising edge, return 1 after it.
  task automatic step();
    @(negedge clk);
    model_expect();
    {s_en, s_wr, s_ifv, s_dfv, s_idone, s_ddone, s_busy} =
      {mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done, busy};
    s_maddr = mem_addr; s_mwdata = mem_wdata; s_faddr = fill_addr; s_fdata = fill_data;
    chk("ctl{en,wr,ifv,dfv,idone,ddone,busy}",
        64'({s_en, s_wr, s_ifv, s_dfv, s_idone, s_ddone, s_busy}),
        64'({e_en, e_wr, e_ifv, e_dfv, e_idone, e_ddone, e_busy}));
    if (e_en) chk("mem_addr", 64'(s_maddr), 64'(e_maddr));
    if (e_en && e_wr) chk("mem_wdata", 64'(s_mwdata), 64'(e_mwdata));
    if (e_ifv || e_dfv) begin
      chk("fill_addr", 64'(s_faddr), 64'(e_faddr));
      chk("fill_data", 64'(s_fdata), 64'(e_faddr ^ 16'h5A5A));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] e_first;
    logic [15:0] e_last;
    int          e_n;
    int          e_beats;
  } vec_t;

  vec_t        vecs [6];
  int          n, beats, nd;
  logic        done, first_seen;
  logic [15:0] first, last;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1230, 16'h123E, 13, 8};
    vecs[1] = '{1'b1, 1'b1, 16'h4002, 16'hBEEF, 16'h4002, 16'h4002, 2, 0};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0, 16'hFFFE, 13, 8};
    vecs[3] = '{1'b0, 1'b0, 16'h000F, 16'h0000, 16'h0000, 16'h000E, 13, 8};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 2, 0};
    vecs[5] = '{1'b1, 1'b0, 16'h8ABC, 16'h0000, 16'h8AB0, 16'h8ABE, 13, 8};

    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    chk("reset_outputs",
        64'({mem_en, mem_wr, mem_addr, mem_wdata, i_fill_valid, d_fill_valid, i_done, d_done, busy}), 64'(0));
    chk("reset_fill_addr", 64'(fill_addr), 64'(0));
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].is_d) begin
        d_req = 1'b1; d_wr = vecs[v].wr; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr;
      end
      n = 0; beats = 0; done = 1'b0; first_seen = 1'b0; first = '0; last = '0;
      while (!done && n < 40) begin
        step();
        n++;
        if (s_en && !first_seen) begin first = s_maddr; first_seen = 1'b1; end
        if (s_en && s_wr) last = s_maddr;
        if (s_ifv || s_dfv) begin last = s_faddr; beats++; end
        if (s_idone || s_ddone) done = 1'b1;
      end
      i_req = 1'b0; d_req = 1'b0;
      chk($sformatf("vec%0d_done", v), 64'(done), 64'(1));
      chk($sformatf("vec%0d_first_addr", v), 64'(first), 64'(vecs[v].e_first));
      chk($sformatf("vec%0d_last_addr", v), 64'(last), 64'(vecs[v].e_last));
      chk($sformatf("vec%0d_cycles", v), 64'(n), 64'(vecs[v].e_n));
      chk($sformatf("vec%0d_beats", v), 64'(beats), 64'(vecs[v].e_beats));
      step();
    end

    // Simultaneous fills: dcache first, one IDLE cycle, then icache.
    i_req = 1'b1; i_addr = 16'h2468;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1357;
    n = 0; done = 1'b0; nd = 0;
    while (!done && n < 40) begin
      step(); n++;
      if (s_idone) nd++;
      if (s_ddone) done = 1'b1;
    end
    d_req = 1'b0;
    chk("both_d_first", 64'({done, 8'(nd)}), 64'({1'b1, 8'd0}));
    step();
    chk("both_gap_idle", 64'({s_en, s_busy}), 64'(0));
    step();
    chk("both_i_start", 64'({s_en, s_wr, s_maddr}), 64'({1'b1, 1'b0, 16'h2460}));
    n = 0; done = 1'b0;
    while (!done && n < 40) begin step(); n++; if (s_idone) done = 1'b1; end
    i_req = 1'b0;
    chk("both_i_done", 64'(done), 64'(1));
    step();

    // Starvation: stores held continuously with icache pending.
    i_req = 1'b1; i_addr = 16'hA000;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h5555;
    n = 0; done = 1'b0; nd = 0;
    while (!done && n < 100) begin
      step(); n++;
      if (s_ddone) nd++;
      if (s_idone) done = 1'b1;
    end
    chk("starve_i_done", 64'(done), 64'(1));
    chk("starve_d_grants", 64'(nd), 64'(LIM));
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      step(); n++;
      if (s_idone || s_ddone) done = 1'b1;
    end
    chk("starve_cleared_d_wins", 64'({s_ddone, s_idone}), 64'({1'b1, 1'b0}));
    d_req = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin step(); n++; if (s_idone) done = 1'b1; end
    i_req = 1'b0;
    chk("starve_i_second", 64'(done), 64'(1));
    step();

    // Spurious valid while idle, then an extra valid right after the 8th beat.
    spur = 1'b1; spur_data = 16'hDEAD;
    step();
    spur = 1'b0;
    chk("spur_idle", 64'({s_ifv, s_dfv}), 64'(0));
    i_req = 1'b1; i_addr = 16'h5550;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin step(); n++; if (s_idone) done = 1'b1; end
    i_req = 1'b0;
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_after_8", 64'({done, s_ifv, s_dfv}), 64'({1'b1, 2'b00}));
    step();

    // Reset asserted during the third beat of a dcache fill.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7770;
    n = 0; beats = 0;
    while (beats < 2 && n < 40) begin step(); n++; if (s_dfv) beats++; end
    chk("rst_two_beats", 64'(beats), 64'(2));
    #2;
    chk("rst_beat3_live", 64'({d_fill_valid, busy}), 64'({1'b1, 1'b1}));
    rst_n = 1'b0;
    m_active = 1'b0; m_starve = 0;
    #1;
    chk("rst_async_outputs",
        64'({mem_en, mem_wr, mem_addr, mem_wdata, i_fill_valid, d_fill_valid, i_done, d_done, busy}), 64'(0));
    d_req = 1'b0;
    repeat (6) step();
    rst_n = 1'b1;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7770;
    n = 0; beats = 0; done = 1'b0; first_seen = 1'b0; first = '0;
    while (!done && n < 40) begin
      step(); n++;
      if (s_en && !first_seen) begin first = s_maddr; first_seen = 1'b1; end
      if (s_dfv) beats++;
      if (s_ddone) done = 1'b1;
    end
    d_req = 1'b0;
    chk("restart_k0_addr", 64'(first), 64'(16'h7770));
    chk("restart_beats", 64'({done, 8'(beats)}), 64'({1'b1, 8'd8}));
    step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2500; c++) begin
      step();
      if (!i_req || s_idone) begin
        i_req  = ($urandom_range(0, 3) == 0);
        i_addr = 16'($urandom);
      end else if (m_active && m_kind == 0 && $urandom_range(0, 15) == 0) begin
        i_req = 1'b0;
      end
      if (!d_req || s_ddone) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_wr    = 1'($urandom);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
      end else if (m_active && m_kind == 1 && $urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      spur      = !m_active && ($urandom_range(0, 4) == 0);
      spur_data = 16'($urandom);
    end
    spur = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
